// File: rtl/arb_pkg.sv
// arb_pkg: shared sizing, FSM encoding and reset constants for the 16-way round-robin arbiter.
package arb_pkg;
    localparam int NUM_REQ = 16;
    localparam int ID_W = 4;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    localparam logic [ID_W-1:0] LAST_ID_RST = 4'd15;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick; rotate so last_id+1 lands at bit 0, find first set, rotate back.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pick_id,
    output logic               any
);
    logic [ID_W-1:0]    start;
    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    ffs;
    assign start = last_id + ID_W'(1);
    // A left shift by NUM_REQ yields zero, so start=0 needs no special case.
    assign rot = (req >> start) | (req << (5'(NUM_REQ) - {1'b0, start}));
    assign any = |req;
    always_comb begin
        ffs = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) ffs = ID_W'(i);
    end
    assign pick_id = ffs + start;
    assign pick = any ? (NUM_REQ'(1) << pick_id) : '0;
endmodule

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with registered one-hot grant and binary id.
// Optional forced revocation after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter16
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid,
    output logic               timeout
);
    state_t             state, state_n;
    logic [NUM_REQ-1:0] grant_n, pick;
    logic [ID_W-1:0]    grant_id_n, last_id, last_id_n, pick_id;
    logic               any, hold_expired;

    rr_pick u_pick (
        .req     (req),
        .last_id (last_id),
        .pick    (pick),
        .pick_id (pick_id),
        .any     (any)
    );

`ifdef ARB_TIMEOUT_EN
    logic [15:0] hold_cnt, hold_cnt_n;
    logic        timeout_n;
    assign hold_expired = (state == GRANT) && (hold_cnt == 16'(HOLD_MAX - 1));
    always_comb begin
        hold_cnt_n = (state == IDLE) ? '0 : hold_cnt + 16'd1;
        timeout_n = hold_expired && req[grant_id];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_n;
            timeout  <= timeout_n;
        end
    end
`else
    localparam int unused_hold_max = HOLD_MAX;
    assign hold_expired = 1'b0;
    assign timeout = 1'b0;
`endif

    // Other requesters are only looked at from IDLE, which forces one idle cycle between owners.
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        grant_id_n = grant_id;
        last_id_n  = last_id;
        if (state == IDLE) begin
            if (enable && any) begin
                state_n    = GRANT;
                grant_n    = pick;
                grant_id_n = pick_id;
                last_id_n  = pick_id;
            end
        end else if (!req[grant_id] || hold_expired) begin
            state_n    = IDLE;
            grant_n    = '0;
            grant_id_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            last_id  <= LAST_ID_RST;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            grant_id <= grant_id_n;
            last_id  <= last_id_n;
        end
    end

    assign grant_valid = |grant;
endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: scoreboard bench; an ownership-level reference model queues expected outputs per edge.
module tb_rr_arbiter16;
    localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset, enable;
    logic [15:0] req, grant;
    logic [3:0]  grant_id;
    logic        grant_valid, timeout;

    rr_arbiter16 #(.HOLD_MAX(HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [21:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: who owns the resource, how long, and who was served last.
    int m_owner = -1, m_last = 15, m_hold = 0;
    bit m_to = 1'b0;
    logic [15:0] e_grant;
    logic [3:0]  e_id;
    always @(posedge clk) begin
        m_to = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_last = 15;
            m_hold = 0;
        end else if (m_owner < 0) begin
            if (enable && req != 16'h0) begin
                for (int k = 1; k <= 16; k++)
                    if (m_owner < 0 && req[(m_last + k) % 16]) m_owner = (m_last + k) % 16;
                m_last = m_owner;
                m_hold = 1;
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else if (TO_EN && m_hold == HOLD) begin
            m_owner = -1;
            m_to = 1'b1;
        end else begin
            m_hold++;
        end
        e_grant = (m_owner >= 0) ? 16'(1 << m_owner) : 16'h0;
        e_id = (m_owner >= 0) ? 4'(m_owner) : 4'h0;
        sb.push_back({e_grant, e_id, m_owner >= 0, m_to});
    end

    logic [21:0] e;
    int waitc[16];
    int maxw;
    bit prev_valid = 1'b0;
    always @(posedge clk) begin
        #1;
        if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else begin
            e = sb.pop_front();
            chk("outputs", {10'b0, grant, grant_id, grant_valid, timeout}, {10'b0, e});
        end
        chk("onehot_id", 32'(((grant == 16'h0 && grant_id == 4'h0) || grant == (16'h1 << grant_id))
                              && grant_valid == (grant != 16'h0)), 32'd1);
        for (int i = 0; i < 16; i++)
            if (reset || !req[i]) waitc[i] = 0;
        if (!reset && grant_valid && !prev_valid) begin
            maxw = 0;
            for (int i = 0; i < 16; i++) begin
                if (i == int'(grant_id)) waitc[i] = 0;
                else if (req[i]) waitc[i]++;
                if (waitc[i] > maxw) maxw = waitc[i];
            end
            chk("starvation", 32'(maxw <= 15), 32'd1);
        end
        prev_valid = grant_valid;
    end

    initial begin
        int held, drop_id, cnt1, tos, hcnt, hlim;
        bit pend;
        int seq[$];
        reset = 1'b1;
        enable = 1'b0;
        req = 16'h0;
        repeat (2) @(negedge clk);
        chk("reset_grant", {16'h0, grant}, 32'h0);
        reset = 1'b0;
        // Two requesters, last_id=15 so bit 0 wins first.
        req = 16'h8001;
        enable = 1'b1;
        @(negedge clk);
        chk("first_grant", {12'h0, grant_id, grant}, {12'h0, 4'd0, 16'h0001});
        req[0] = 1'b0;
        @(negedge clk);
        chk("idle_gap", {31'h0, grant_valid}, 32'd0);
        @(negedge clk);
        chk("second_grant", {12'h0, grant_id, grant}, {12'h0, 4'd15, 16'h8000});
        req = 16'h0;
        repeat (3) @(negedge clk);
        // All requesters held high, each owner releases after 3 cycles and re-requests.
        req = 16'hffff;
        held = 0;
        pend = 1'b0;
        drop_id = 0;
        for (int c = 0; c < 120 && seq.size() < 17; c++) begin
            @(negedge clk);
            if (grant_valid) begin
                held++;
                if (held == 1) seq.push_back(int'(grant_id));
                if (held == 3) begin
                    drop_id = int'(grant_id);
                    req[drop_id] = 1'b0;
                    pend = 1'b1;
                end
            end else begin
                held = 0;
                if (pend) req[drop_id] = 1'b1;
                pend = 1'b0;
            end
        end
        chk("seq_len", 32'(seq.size()), 32'd17);
        for (int k = 0; k < seq.size(); k++) chk("rotation", 32'(seq[k]), 32'(k % 16));
        req = 16'h0;
        repeat (4) @(negedge clk);
        // Enable gating and enable drop during ownership.
        enable = 1'b0;
        req = 16'h0010;
        repeat (3) @(negedge clk);
        chk("enable_block", {16'h0, grant}, 32'h0);
        enable = 1'b1;
        @(negedge clk);
        chk("enable_grant", {27'h0, grant_valid, grant_id}, {27'h0, 1'b1, 4'd4});
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("enable_drop_hold", {27'h0, grant_valid, grant_id}, {27'h0, 1'b1, 4'd4});
        req = 16'h0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        // Reset mid-ownership restores last_id to 15.
        req = 16'h0080;
        @(negedge clk);
        chk("pre_reset_id", {28'h0, grant_id}, 32'd7);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset", {10'h0, grant, grant_id, grant_valid, timeout}, 32'h0);
        reset = 1'b0;
        req = 16'h0081;
        @(negedge clk);
        chk("post_reset_id", {27'h0, grant_valid, grant_id}, {27'h0, 1'b1, 4'd0});
        req = 16'h0;
        repeat (2) @(negedge clk);
        // Two persistent requesters: bounded vs. unbounded ownership.
        req = 16'h0006;
        cnt1 = 0;
        tos = 0;
        repeat (10) begin
            @(negedge clk);
            if (grant_valid && grant_id == 4'd1) cnt1++;
            if (timeout) tos++;
        end
        chk("hold_cycles", 32'(cnt1), TO_EN ? 32'd4 : 32'd10);
        chk("timeout_pulses", 32'(tos), TO_EN ? 32'd2 : 32'd0);
        req = 16'h0;
        repeat (3) @(negedge clk);
        // Random traffic: requests stay high until served, owners release after 1..6 cycles.
        hcnt = 0;
        hlim = 3;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            enable = ($urandom_range(7) != 0);
            if (grant_valid && req[grant_id]) begin
                hcnt++;
                if (hcnt >= hlim) begin
                    req[grant_id] = 1'b0;
                    hcnt = 0;
                    hlim = $urandom_range(6, 1);
                end
            end else hcnt = 0;
            for (int i = 0; i < 16; i++)
                if (!(grant_valid && i == int'(grant_id)) && !req[i] && $urandom_range(7) == 0)
                    req[i] = 1'b1;
        end
        req = 16'h0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Round-robin arbiter that shares one 16-way resource among 16 requesters. It turns a 16-bit request vector into a registered one-hot grant plus its 4-bit binary grant index. Rotating priority ensures no requester starves. It sits in front of the 16-input one-hot-to-binary encode path and sequences which source owns it each cycle.

## Interface
Parameters:
- HOLD_MAX, 64: maximum consecutive grant cycles per owner; used only when ARB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  high permits new grants; low blocks arbitration but never revokes a held grant.
- req  input  16  request vector; bit i high = requester i wants the resource; held high for the whole ownership.
- grant  output  16  registered one-hot grant; all-zero when idle.
- grant_id  output  4  binary index of the set grant bit; 0 when idle.
- grant_valid  output  1  high while any grant bit is set.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without ARB_TIMEOUT_EN.

## Operation
- Reset values: grant=0, grant_id=0, grant_valid=0, timeout=0, state=IDLE, last_id=15, hold counter=0.
- States:
  - IDLE: if enable=1 and req≠0, pick the first set req bit scanning last_id+1, last_id+2, … with modulo-16 wrap. Load grant, grant_id and last_id, then go to GRANT. Otherwise stay in IDLE.
  - GRANT: hold the grant while req[grant_id]=1. When req[grant_id]=0, clear the grant and return to IDLE.
- Priority rotates on every grant: the owner just served becomes lowest priority.
- Requests from other requesters during GRANT are ignored; they are only re-evaluated in IDLE.
- grant is always exactly one-hot or zero. grant_id always equals the encoded position of grant.
- enable falling during GRANT has no effect on the current owner.
- reset asserted in any state returns all outputs to their reset values on the next edge, including mid-ownership; last_id returns to 15.

## Timing
- Grant latency: req sampled in IDLE at edge N; grant, grant_id and grant_valid are valid after edge N (registered, 1 cycle).
- Release: the owner drops req before edge M; grant=0 after edge M.
- There is always one IDLE cycle between owners. The earliest next grant is after edge M+1.
- Single persistent requester: granted, released, then re-granted with a 1-cycle gap.
- Wrap-around: with last_id=15, the scan order is 0,1,…,15.
- No combinational path from req to any output.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A hold counter clears on each grant and increments every GRANT cycle.
  - When the counter reaches HOLD_MAX-1 with req still high, the next edge clears the grant, returns to IDLE and pulses timeout for exactly that one cycle.
  - The owner therefore holds at most HOLD_MAX cycles.
  - last_id stays at the revoked owner, so the other requesters are scanned first.
- ARB_TIMEOUT_EN undefined:
  - No counter logic; HOLD_MAX is ignored.
  - timeout is tied to 0 and ownership is unbounded.

## Structure
- Shared package arb_pkg holds:
  - NUM_REQ=16 and ID_W=4;
  - the state encoding (IDLE=0, GRANT=1);
  - the reset value of last_id (15).
- One sub-module, rr_pick, is natural. It is purely combinational: it takes req and last_id and returns a one-hot pick, the binary id and an any flag. It is implemented as a rotate, a fixed-priority find-first-set and a rotate back.
- The top level holds the state register, the output registers and the optional hold counter.

## Test plan
- Reset then req=16'h8001, enable=1 → grant=16'h0001, grant_id=0 one cycle later. Drop req[0] → idle cycle, then grant=16'h8000, grant_id=15.
- All 16 requesters held high, each releasing 3 cycles after its grant → grant_id sequence 0,1,…,15,0 with exactly one idle cycle between owners.
- enable=0 with req=16'h0010 → grant stays 0. Raise enable → grant_id=4 next cycle. Drop enable during GRANT → grant_id stays 4.
- Assert reset mid-GRANT with grant_id=7 → all outputs 0 next edge. After reset release with req=16'h0081 → grant_id=0, because last_id was reset to 15.
- ARB_TIMEOUT_EN with HOLD_MAX=4, req=16'h0006 held constant:
  - grant_id=1 for exactly 4 cycles, then timeout=1 for 1 cycle with grant=0;
  - then grant_id=2 for 4 cycles;
  - without the macro, grant_id=1 is held indefinitely and timeout stays 0.
- Random req/enable/release traffic with a checker:
  - every cycle, grant is one-hot or zero and grant_id matches grant;
  - no requester waits more than 15 ownerships.
